// File: rtl/chess_turn_controller.sv
// Game-flow controller for a timed chess game: START/CHESS/WHITE/BLACK/END sequencing,
// per-player countdown clocks, board cursor tracking and a req/ack redraw request.
module chess_turn_controller #(
  parameter int CLK_HZ            = 50000000,
  parameter int INIT_SECONDS      = 600,
  parameter int INCREMENT_SECONDS = 0,
  parameter int SEC_W             = 12,
  parameter int BOARD_BITS        = 3
) (
  input  logic                  clock,
  input  logic                  resetApp_n,
  input  logic                  startStop,
  input  logic                  moveSwitch,
  input  logic                  keyLeft,
  input  logic                  keyUp,
  input  logic                  keyDown,
  input  logic                  keyRight,
  input  logic                  drawAck,
  output logic                  drawReq,
  output logic [2:0]            state,
  output logic [SEC_W-1:0]      whiteSeconds,
  output logic [SEC_W-1:0]      blackSeconds,
  output logic [BOARD_BITS-1:0] cursorX,
  output logic [BOARD_BITS-1:0] cursorY,
  output logic [1:0]            winner,
  output logic                  paused
);

  localparam int PW = $clog2(CLK_HZ);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_CHESS = 3'd1,
    ST_WHITE = 3'd2,
    ST_BLACK = 3'd3,
    ST_END   = 3'd4
  } state_e;

  localparam logic [SEC_W-1:0] SEC_INIT   = SEC_W'(INIT_SECONDS);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [SEC_W:0]   INC_EXT    = (SEC_W+1)'(INCREMENT_SECONDS);
  localparam bit               INC_BIG    = longint'(INCREMENT_SECONDS) >= (longint'(1) << SEC_W);

  // Add the per-move increment, saturating at the counter's maximum.
  function automatic logic [SEC_W-1:0] sat_add(input logic [SEC_W-1:0] a);
    logic [SEC_W:0] sum;
    sum = {1'b0, a} + INC_EXT;
    if (INC_BIG || sum[SEC_W]) begin
      sat_add = {SEC_W{1'b1}};
    end else begin
      sat_add = sum[SEC_W-1:0];
    end
  endfunction

  state_e                state_q, state_d;
  logic [SEC_W-1:0]      white_q, white_d;
  logic [SEC_W-1:0]      black_q, black_d;
  logic [BOARD_BITS-1:0] cursor_x_q, cursor_x_d;
  logic [BOARD_BITS-1:0] cursor_y_q, cursor_y_d;
  logic [1:0]            winner_q, winner_d;
  logic                  paused_q, paused_d;
  logic                  draw_req_q, draw_req_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  ss_hist_q, ss_hist_d;
  logic                  mv_hist_q, mv_hist_d;
  logic [3:0]            key_hist_q, key_hist_d;

  logic                  ss_rise_s, ss_fall_s, mv_edge_s;
  logic [3:0]            keys_s, key_rise_s;
  logic                  is_white_s, wrap_s, set_req_s;
  logic [SEC_W-1:0]      left_s;
  logic [BOARD_BITS-1:0] step_x_s, step_y_s;

  assign keys_s     = {keyLeft, keyUp, keyDown, keyRight};
  assign key_rise_s = keys_s & ~key_hist_q;
  assign ss_rise_s  = startStop & ~ss_hist_q;
  assign ss_fall_s  = ~startStop & ss_hist_q;
  assign mv_edge_s  = moveSwitch ^ mv_hist_q;
  // Opposite keys cancel through the plain add/subtract; wrap is the natural modulo.
  assign step_x_s   = cursor_x_q + BOARD_BITS'(key_rise_s[0]) - BOARD_BITS'(key_rise_s[3]);
  assign step_y_s   = cursor_y_q + BOARD_BITS'(key_rise_s[1]) - BOARD_BITS'(key_rise_s[2]);

  // Next-state, timer, cursor and redraw-request computation.
  always_comb begin
    state_d    = state_q;
    white_d    = white_q;
    black_d    = black_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    winner_d   = winner_q;
    presc_d    = presc_q;
    set_req_s  = 1'b0;
    is_white_s = (state_q == ST_WHITE);
    wrap_s     = (presc_q == PRESC_LAST);
    left_s     = is_white_s ? white_q : black_q;
    ss_hist_d  = startStop;
    mv_hist_d  = moveSwitch;
    key_hist_d = keys_s;

    case (state_q)
      ST_START: begin
        white_d  = SEC_INIT;
        black_d  = SEC_INIT;
        winner_d = 2'b00;
        presc_d  = '0;
        if (ss_rise_s) begin
          state_d   = ST_CHESS;
          set_req_s = 1'b1;
        end else begin
          state_d = ST_START;
        end
      end
      ST_CHESS: begin
        presc_d = '0;
        if (draw_req_q && drawAck) begin
          state_d    = ST_WHITE;
          cursor_x_d = '0;
          cursor_y_d = '0;
        end else begin
          state_d = ST_CHESS;
        end
      end
      ST_WHITE, ST_BLACK: begin
        if (startStop) begin
          presc_d = wrap_s ? '0 : presc_q + PW'(1);
          if (wrap_s && (left_s != '0)) begin
            left_s = left_s - SEC_W'(1);
          end else begin
            left_s = left_s;
          end
          // Expiry outranks a move committed in the same cycle.
          if (wrap_s && (left_s == '0)) begin
            state_d   = ST_END;
            winner_d  = is_white_s ? 2'b10 : 2'b01;
            set_req_s = 1'b1;
          end else if (mv_edge_s) begin
            left_s    = sat_add(left_s);
            presc_d   = '0;
            state_d   = is_white_s ? ST_BLACK : ST_WHITE;
            set_req_s = 1'b1;
          end else begin
            state_d = state_q;
          end
          if (is_white_s) begin
            white_d = left_s;
          end else begin
            black_d = left_s;
          end
          cursor_x_d = step_x_s;
          cursor_y_d = step_y_s;
          if ((step_x_s != cursor_x_q) || (step_y_s != cursor_y_q)) begin
            set_req_s = 1'b1;
          end else begin
            set_req_s = set_req_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_END: begin
        presc_d = '0;
        if (ss_fall_s) begin
          state_d   = ST_START;
          white_d   = SEC_INIT;
          black_d   = SEC_INIT;
          winner_d  = 2'b00;
          set_req_s = 1'b1;
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d = ST_START;
        presc_d = '0;
      end
    endcase

    // A set event in the acknowledge cycle keeps the request alive.
    draw_req_d = set_req_s | (draw_req_q & ~drawAck);
    paused_d   = ((state_d == ST_WHITE) || (state_d == ST_BLACK)) & ~startStop;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      state_q    <= ST_START;
      white_q    <= SEC_INIT;
      black_q    <= SEC_INIT;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      winner_q   <= 2'b00;
      paused_q   <= 1'b0;
      draw_req_q <= 1'b0;
      presc_q    <= '0;
      ss_hist_q  <= 1'b0;
      mv_hist_q  <= 1'b0;
      key_hist_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      white_q    <= white_d;
      black_q    <= black_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      winner_q   <= winner_d;
      paused_q   <= paused_d;
      draw_req_q <= draw_req_d;
      presc_q    <= presc_d;
      ss_hist_q  <= ss_hist_d;
      mv_hist_q  <= mv_hist_d;
      key_hist_q <= key_hist_d;
    end
  end

  assign state        = state_q;
  assign whiteSeconds = white_q;
  assign blackSeconds = black_q;
  assign cursorX      = cursor_x_q;
  assign cursorY      = cursor_y_q;
  assign winner       = winner_q;
  assign paused       = paused_q;
  assign drawReq      = draw_req_q;

endmodule

// File: doc/chess_turn_controller.md
Name: chess_turn_controller

Overview:
- Parametrised game-flow controller for the timed chess game.
- Sequences START, CHESS, WHITE, BLACK and END, and runs a countdown clock per player with a configurable tick rate, start time and per-move increment.
- Tracks an 8x8 (generalised 2^BOARD_BITS) cursor from the four direction keys.
- Requests screen redraws from the display/render path over a req/ack handshake.

Parameters:
CLK_HZ, 50000000, clock cycles per game second (>=2)
INIT_SECONDS, 600, starting time per player in seconds
INCREMENT_SECONDS, 0, seconds added to the mover on each committed move
SEC_W, 12, width of each player time counter
BOARD_BITS, 3, cursor coordinate width; board is 2^BOARD_BITS squares per side

Ports:
clock  in  1  system clock
resetApp_n  in  1  asynchronous active-low reset
startStop  in  1  level switch, pre-synchronised; rising edge starts a game, low pauses, falling edge in END returns to START
moveSwitch  in  1  level switch, pre-synchronised; any edge commits the current player's move
keyLeft  in  1  direction key, pre-synchronised, active-high level
keyUp  in  1  direction key, pre-synchronised, active-high level
keyDown  in  1  direction key, pre-synchronised, active-high level
keyRight  in  1  direction key, pre-synchronised, active-high level
drawAck  in  1  renderer accepted the redraw request
drawReq  out  1  redraw request, held until acknowledged
state  out  3  0 START, 1 CHESS, 2 WHITE, 3 BLACK, 4 END
whiteSeconds  out  SEC_W  white remaining time
blackSeconds  out  SEC_W  black remaining time
cursorX  out  BOARD_BITS  cursor column
cursorY  out  BOARD_BITS  cursor row
winner  out  2  00 none, 01 white, 10 black
paused  out  1  high in WHITE/BLACK while startStop is low

Behaviour:
- Reset (asynchronous, resetApp_n low), all outputs take these values:
  - state=START, drawReq=0, winner=00, paused=0.
  - whiteSeconds=blackSeconds=INIT_SECONDS, cursorX=cursorY=0.
  - Prescaler and edge-detect history registers cleared.
  - Edge history cleared to 0, so a switch already high at release produces a rising edge on the first clock.
- Edge detection: one-cycle registered history per input; an edge is acted on in the cycle it is first seen. State change takes effect on the next clock edge.
- START:
  - Timers held at INIT_SECONDS; winner=00.
  - startStop rising edge -> CHESS; drawReq set.
- CHESS:
  - Waits for drawAck high while drawReq is high.
  - On that cycle: drawReq cleared and -> WHITE. Cursor reset to 0,0.
- WHITE/BLACK (active player P):
  - paused = !startStop. While paused, the prescaler holds, and key and move edges are ignored (discarded, not queued).
  - Running: prescaler counts 0..CLK_HZ-1. At the wrap cycle, P's seconds decrement by 1.
  - Decrement to 0 -> END in the same cycle, winner = other player, drawReq set.
  - A counter already at 0 never underflows.
  - moveSwitch edge while running:
    - P's seconds += INCREMENT_SECONDS, saturating at 2^SEC_W-1.
    - Prescaler cleared; state -> other player; drawReq set.
  - Simultaneous expiry-decrement and move edge in the same cycle: expiry wins (END, no increment).
  - Key rising edges while running:
    - Left: cursorX-1. Right: cursorX+1. Up: cursorY-1. Down: cursorY+1.
    - Modulo 2^BOARD_BITS (wrap: 0-1 -> 7, 7+1 -> 0 for BOARD_BITS=3).
    - Multiple keys in the same cycle are each applied; opposite keys cancel.
    - Any cursor change sets drawReq.
- END:
  - Timers and winner frozen; keys and moveSwitch ignored.
  - startStop falling edge -> START: timers reloaded, winner=00, drawReq set.
- drawReq handshake:
  - Set events assert drawReq; it stays high until a cycle where drawAck=1, and clears on the following edge.
  - A new set event in the same cycle as acknowledgement keeps drawReq high, so the request is not lost.
  - Multiple pending requests merge into one.
  - drawAck while drawReq=0 is ignored.
- Illegal state encoding (5-7) -> START on the next clock.
- Reset asserted mid-game: immediate return to reset values; no drawReq emitted on release.

Test Plan:
All scenarios use CLK_HZ=4, INIT_SECONDS=3, INCREMENT_SECONDS=1, SEC_W=4, BOARD_BITS=3, and the renderer acks one cycle after each drawReq.
1. Reset release, startStop 0->1 -> state START->CHESS, drawReq=1. After ack -> WHITE, drawReq=0, whiteSeconds=3, blackSeconds=3.
2. WHITE running 8 clocks -> whiteSeconds 3->2->1 (one decrement every 4 clocks). Then moveSwitch toggle -> whiteSeconds=2, state=BLACK, drawReq pulse.
3. BLACK, startStop low for 20 clocks -> paused=1, blackSeconds unchanged, key presses ignored. startStop high -> counting resumes from the held prescaler value.
4. BLACK runs 12 clocks from 3 -> blackSeconds=0, state=END, winner=01. Subsequent moveSwitch edge -> no change. startStop falling -> START, both timers=3, winner=00.
5. From cursor 0,0: keyLeft, keyUp -> 7,7. keyRight -> 0,7. keyLeft+keyRight together -> 0,7. Each changing press yields one acked drawReq.
6. Move edge coincident with white's final decrement -> END with winner=10 and whiteSeconds=0, not incremented. Separately, hold drawAck low across two set events -> exactly one drawReq high period until ack.
